z80_bus_arbiter: RTL and testbench

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

---
 rtl/z80_arb_pkg.sv | 15 +
 rtl/z80_wait_cnt.sv | 25 ++
 rtl/z80_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_arb_pkg.sv
// Shared FSM states and parameter defaults for the Z80 / loader RAM arbiter.
package z80_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_HOLD,
    LD_ACC,
    LD_DONE
  } arb_state_t;

  localparam int DEF_WAIT_STATES = 1;
  localparam int DEF_STARVE_MAX  = 4;

endpackage

// File: rtl/z80_wait_cnt.sv
// Loadable down-counter that stretches a CPU access by WAIT_STATES cycles.
module z80_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares one synchronous RAM between a Z80 CPU and a loader port.
// Define Z80_ARB_STARVE_GUARD_EN to force a loader grant after STARVE_MAX CPU wins.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int STARVE_MAX  = DEF_STARVE_MAX
) (
  input  logic        i_clk,
  input  logic        i_reset_btn,
  input  logic        i_cpu_mreq_n,
  input  logic        i_cpu_rd_n,
  input  logic        i_cpu_wr_n,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_dout,
  output logic [7:0]  o_cpu_din,
  output logic        o_cpu_wait_n,
  input  logic        i_ld_req,
  input  logic        i_ld_we,
  input  logic [15:0] i_ld_addr,
  input  logic [7:0]  i_ld_wdata,
  output logic        o_ld_gnt,
  output logic        o_ld_ack,
  output logic [7:0]  o_ld_rdata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata
);

  arb_state_t  st, nxt;
  logic        cpu_req;
  logic        cnt_zero;
  logic        first_q;
  logic        acc_start;
  logic        ld_force;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  din_q;

  assign cpu_req   = ~i_cpu_mreq_n & (~i_cpu_rd_n | ~i_cpu_wr_n);
  assign acc_start = (st == IDLE) && (nxt == CPU_ACC);

`ifdef Z80_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;

  always_ff @(posedge i_clk) begin
    if (i_reset_btn) begin
      starve_q <= '0;
    end else if (st == IDLE && nxt == LD_ACC) begin
      starve_q <= '0;
    end else if (acc_start && i_ld_req) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  assign ld_force = i_ld_req && (starve_q == SW'(STARVE_MAX));
`else
  logic unused_starve;
  assign unused_starve = (STARVE_MAX > 0);
  assign ld_force      = 1'b0;
`endif

  z80_wait_cnt u_wait (
    .clk      (i_clk),
    .rst      (i_reset_btn),
    .load     (acc_start),
    .dec      (st == CPU_ACC),
    .load_val (3'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: begin
        if (ld_force)      nxt = LD_ACC;
        else if (cpu_req)  nxt = CPU_ACC;
        else if (i_ld_req) nxt = LD_ACC;
      end
      CPU_ACC:  if (cnt_zero) nxt = CPU_HOLD;
      CPU_HOLD: if (i_cpu_mreq_n) nxt = IDLE;
      LD_ACC:   nxt = LD_DONE;
      LD_DONE:  nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // A CPU that lost arbitration is stalled until its own access ends.
  always_comb begin
    o_mem_addr   = addr_q;
    o_mem_wdata  = wdata_q;
    o_mem_we     = 1'b0;
    o_ld_gnt     = 1'b0;
    o_ld_ack     = 1'b0;
    o_ld_rdata   = '0;
    o_cpu_wait_n = 1'b1;
    unique case (st)
      IDLE: o_cpu_wait_n = ~(cpu_req & ld_force);
      CPU_ACC: begin
        o_mem_wdata  = i_cpu_dout;
        o_cpu_wait_n = cnt_zero;
        if (first_q) begin
          o_mem_addr = i_cpu_addr;
          o_mem_we   = ~i_cpu_wr_n;
        end
      end
      LD_ACC: begin
        o_ld_gnt     = 1'b1;
        o_mem_addr   = i_ld_addr;
        o_mem_we     = i_ld_we;
        o_mem_wdata  = i_ld_wdata;
        o_cpu_wait_n = ~cpu_req;
      end
      LD_DONE: begin
        o_ld_ack     = 1'b1;
        o_ld_rdata   = i_mem_rdata;
        o_cpu_wait_n = ~cpu_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_btn) begin
      st      <= IDLE;
      first_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
    end else begin
      st      <= nxt;
      first_q <= acc_start;
      if (st == CPU_ACC || st == LD_ACC) begin
        addr_q  <= o_mem_addr;
        wdata_q <= o_mem_wdata;
      end
      if (st == CPU_ACC && cnt_zero) begin
        din_q <= i_mem_rdata;
      end
    end
  end

  assign o_cpu_din = din_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed scoreboard bench for z80_bus_arbiter (WAIT_STATES=1, STARVE_MAX=4).
// Expectations follow Z80_ARB_STARVE_GUARD_EN when it is defined.
`timescale 1ns/1ps
module tb_z80_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq_n, rd_n, wr_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  o_cpu_din;
  logic        o_cpu_wait_n;
  logic        ld_req, ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        o_ld_gnt, o_ld_ack;
  logic [7:0]  o_ld_rdata;
  logic [15:0] o_mem_addr;
  logic        o_mem_we;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  bit          ram_ok [0:65535];
  logic [7:0]  sh [0:65535];
  bit          sh_ok [0:65535];
  logic [7:0]  exp_q [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  z80_bus_arbiter #(.WAIT_STATES(1), .STARVE_MAX(4)) dut (
    .i_clk        (clk),
    .i_reset_btn  (rst),
    .i_cpu_mreq_n (mreq_n),
    .i_cpu_rd_n   (rd_n),
    .i_cpu_wr_n   (wr_n),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_dout   (cpu_dout),
    .o_cpu_din    (o_cpu_din),
    .o_cpu_wait_n (o_cpu_wait_n),
    .i_ld_req     (ld_req),
    .i_ld_we      (ld_we),
    .i_ld_addr    (ld_addr),
    .i_ld_wdata   (ld_wdata),
    .o_ld_gnt     (o_ld_gnt),
    .o_ld_ack     (o_ld_ack),
    .o_ld_rdata   (o_ld_rdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hBD;
  endfunction

  function automatic logic [7:0] sh_read(input logic [15:0] a);
    return sh_ok[a] ? sh[a] : init_byte(a);
  endfunction

  // RAM: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (o_mem_we) begin
      ram[o_mem_addr]    <= o_mem_wdata;
      ram_ok[o_mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_ok[o_mem_addr] ? ram[o_mem_addr]
                                    : init_byte(o_mem_addr);
  end

  task automatic check_reset_vals(input string nm);
    logic [43:0] got, want;
    got  = {o_cpu_wait_n, o_cpu_din, o_ld_gnt, o_ld_ack, o_ld_rdata,
            o_mem_we, o_mem_addr, o_mem_wdata};
    want = {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cpu_op(input bit wr, input logic [15:0] a,
                        input logic [7:0] d, input string nm);
    int lows = 0, wes = 0;
    bit done = 0, hold_bad = 0;
    logic [15:0] acc_addr = '0, we_addr = '0;
    logic [7:0]  we_data = '0, e;
    if (!wr) exp_q.push_back(sh_read(a));
    @(posedge clk); #1;
    cpu_addr = a; cpu_dout = d;
    mreq_n = 1'b0; rd_n = wr; wr_n = ~wr;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (o_mem_we) begin
        wes++; we_addr = o_mem_addr; we_data = o_mem_wdata;
      end
      if (!o_cpu_wait_n) begin
        if (lows == 0) acc_addr = o_mem_addr;
        lows++;
      end else if (lows > 0) begin
        done = 1;
      end
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL %s_timeout: got no access, want done", nm);
    end
    total++;
    if (lows !== 1) begin
      bad++; $display("FAIL %s_wait_cycles: got %0d want 1", nm, lows);
    end
    total++;
    if (acc_addr !== a) begin
      bad++; $display("FAIL %s_addr: got %h want %h", nm, acc_addr, a);
    end
    total++;
    if (wr && (wes !== 1 || we_addr !== a || we_data !== d)) begin
      bad++;
      $display("FAIL %s_write: got n=%0d %h/%h want 1 %h/%h",
               nm, wes, we_addr, we_data, a, d);
    end else if (!wr && wes !== 0) begin
      bad++; $display("FAIL %s_we: got %0d strobes want 0", nm, wes);
    end
    if (wr) begin
      sh[a] = d; sh_ok[a] = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    if (!wr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total++;
      if (o_cpu_din !== e) begin
        bad++; $display("FAIL %s_din: got %h want %h", nm, o_cpu_din, e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_cpu_wait_n !== 1'b1 || o_mem_we !== 1'b0) hold_bad = 1;
    end
    total++;
    if (hold_bad) begin
      bad++; $display("FAIL %s_hold: got repeat access want single", nm);
    end
    @(posedge clk); #1;
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic ld_op(input bit we, input logic [15:0] a,
                       input logic [7:0] d, input string nm,
                       output int gc, output int ac);
    logic [7:0] e;
    exp_q.push_back(sh_read(a));
    if (we) begin
      sh[a] = d; sh_ok[a] = 1'b1;
    end
    gc = -1; ac = -1;
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    for (int c = 0; c < 20 && ac < 0; c++) begin
      @(negedge clk);
      if (o_ld_ack) begin
        ac = c;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (o_ld_rdata !== e) begin
          bad++; $display("FAIL %s_rdata: got %h want %h", nm, o_ld_rdata, e);
        end
      end
      if (o_ld_gnt && gc < 0) begin
        gc = c;
        total++;
        if ({o_mem_addr, o_mem_we, o_mem_wdata} !== {a, we, we ? d : o_mem_wdata}) begin
          bad++;
          $display("FAIL %s_mem: got %h/%b/%h want %h/%b/%h",
                   nm, o_mem_addr, o_mem_we, o_mem_wdata, a, we, d);
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
      end
    end
    ld_req = 1'b0;
    total++;
    if (ac < 0) begin
      bad++; $display("FAIL %s_timeout: got no ack want ack", nm);
    end
  endtask

  task automatic test_cpu_read();
    cpu_op(1'b0, 16'h0001, 8'h00, "cpu_read");
  endtask

  task automatic test_cpu_write();
    cpu_op(1'b1, 16'h1234, 8'h5A, "cpu_write");
  endtask

  task automatic test_loader();
    int gc, ac;
    ld_op(1'b1, 16'h0002, 8'hAA, "ld_write", gc, ac);
    total++;
    if (gc !== 1 || ac !== 2) begin
      bad++; $display("FAIL ld_timing: got gnt=%0d ack=%0d want 1 2", gc, ac);
    end
    ld_op(1'b0, 16'h0002, 8'h00, "ld_read_a", gc, ac);
    ld_op(1'b0, 16'h1234, 8'h00, "ld_read_b", gc, ac);
  endtask

  task automatic test_back_to_back();
    int g0 = -1, g1 = -1, acks = 0;
    logic [7:0] e;
    exp_q.push_back(sh_read(16'h0002));
    exp_q.push_back(sh_read(16'h0002));
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0002;
    for (int c = 0; c < 30 && acks < 2; c++) begin
      @(negedge clk);
      if (o_ld_gnt) begin
        if (g0 < 0) g0 = c;
        else g1 = c;
      end
      if (o_ld_ack) begin
        acks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (o_ld_rdata !== e) begin
          bad++; $display("FAIL b2b_rdata: got %h want %h", o_ld_rdata, e);
        end
      end
      @(posedge clk); #1;
      if (g1 >= 0) ld_req = 1'b0;
    end
    ld_req = 1'b0;
    total++;
    if (acks !== 2 || g1 - g0 !== 3) begin
      bad++;
      $display("FAIL b2b_spacing: got acks=%0d gap=%0d want 2 3", acks, g1 - g0);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int gc = -1, ac = -1, lows = 0, rel = -1;
    logic [7:0] e;
    exp_q.push_back(sh_read(16'h0002));
    exp_q.push_back(sh_read(16'h1234));
    @(posedge clk); #1;
    cpu_addr = 16'h0002; mreq_n = 1'b0; rd_n = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h1234;
    for (int c = 0; c < 30 && ac < 0; c++) begin
      @(negedge clk);
      if (o_ld_gnt && gc < 0) gc = c;
      if (o_ld_ack) begin
        ac = c;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (o_ld_rdata !== e) begin
          bad++; $display("FAIL cont_ld_rdata: got %h want %h", o_ld_rdata, e);
        end
      end
      if (c == rel) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (o_cpu_din !== e) begin
          bad++; $display("FAIL cont_cpu_din: got %h want %h", o_cpu_din, e);
        end
      end
      if (rel < 0) begin
        if (!o_cpu_wait_n) lows++;
        else if (lows > 0) rel = c + 1;
      end
      @(posedge clk); #1;
      if (rel >= 0) begin
        mreq_n = 1'b1; rd_n = 1'b1;
      end
      if (gc >= 0) ld_req = 1'b0;
    end
    mreq_n = 1'b1; rd_n = 1'b1; ld_req = 1'b0;
    total++;
    if (rel < 0 || gc !== rel + 2 || ac !== rel + 3) begin
      bad++;
      $display("FAIL cont_order: got hold=%0d gnt=%0d ack=%0d want gnt=hold+2 ack=hold+3",
               rel, gc, ac);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_starve();
    int done_cnt = 0, lows = 0, at_gnt = -1, ph = 0, want;
    bit ack_seen = 0;
    logic [7:0] e;
`ifdef Z80_ARB_STARVE_GUARD_EN
    want = 4;
`else
    want = 6;
`endif
    exp_q.push_back(sh_read(16'h0002));
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0002;
    cpu_addr = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
    for (int c = 0; c < 300 && !ack_seen; c++) begin
      @(negedge clk);
      if (o_ld_gnt && at_gnt < 0) at_gnt = done_cnt;
      if (o_ld_ack) begin
        ack_seen = 1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (o_ld_rdata !== e) begin
          bad++; $display("FAIL starve_rdata: got %h want %h", o_ld_rdata, e);
        end
      end
      if (ph == 0) begin
        if (!o_cpu_wait_n) lows++;
        else if (lows > 0) begin
          done_cnt++; lows = 0; ph = 1;
        end
      end
      @(posedge clk); #1;
      if (at_gnt >= 0) ld_req = 1'b0;
      if (ph == 1) begin
        mreq_n = 1'b1; rd_n = 1'b1; ph = 2;
      end else if (ph == 2 && at_gnt < 0 && done_cnt < 6) begin
        mreq_n = 1'b0; rd_n = 1'b0; ph = 0;
      end
    end
    mreq_n = 1'b1; rd_n = 1'b1; ld_req = 1'b0;
    total++;
    if (!ack_seen || at_gnt !== want) begin
      bad++;
      $display("FAIL starve_grant: got %0d cpu accesses before loader want %0d",
               at_gnt, want);
    end
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int acks = 0;
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h1234;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (o_ld_gnt) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL rst_mid_gnt: got no grant want grant");
    end
    rst = 1'b1; ld_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_mid_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_ld_ack) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("FAIL rst_mid_ack: got %0d acks want 0", acks);
    end
  endtask

  initial begin
    rst = 1'b1;
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    cpu_addr = '0; cpu_dout = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_loader();
    test_back_to_back();
    test_contention();
    test_starve();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
